// File: rtl/mesi_snoop_bus_ctrl_if.sv
// Snoop-bus interface between the per-CPU MESI caches and the central
// snoop-bus controller.
//   master : cache side; drives requests, snoop responses and write/supply data.
//   slave  : controller side; drives grant, snoop broadcast, fill data,
//            completion pulses, shared indication and error pulse.
// Lane k of every per-cache vector belongs to cache k.
interface mesi_snoop_bus_ctrl_if #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256
);
    logic [NUM_CACHES-1:0]            req;
    logic [3*NUM_CACHES-1:0]          req_op;
    logic [ADDR_WIDTH*NUM_CACHES-1:0] req_addr;
    logic [LINE_BITS*NUM_CACHES-1:0]  req_wdata;
    logic [NUM_CACHES-1:0]            req_wvalid;
    logic [NUM_CACHES-1:0]            snp_shared;
    logic [NUM_CACHES-1:0]            snp_supply;
    logic [NUM_CACHES-1:0]            grant;
    logic [3*NUM_CACHES-1:0]          snoop_op;
    logic [ADDR_WIDTH-1:0]            snoop_addr;
    logic [LINE_BITS-1:0]             rdata;
    logic [NUM_CACHES-1:0]            data_ready;
    logic                             shared_out;
    logic                             err;

    modport master (
        output req, req_op, req_addr, req_wdata, req_wvalid, snp_shared, snp_supply,
        input  grant, snoop_op, snoop_addr, rdata, data_ready, shared_out, err
    );

    modport slave (
        input  req, req_op, req_addr, req_wdata, req_wvalid, snp_shared, snp_supply,
        output grant, snoop_op, snoop_addr, rdata, data_ready, shared_out, err
    );
endinterface

// File: rtl/mesi_snoop_bus_ctrl.sv
// Central snoop-bus controller for NUM_CACHES MESI caches.
// Round-robin arbitrates bus requests, broadcasts the granted op to every other
// cache, collects shared/supply responses, then serves the line from a supplying
// cache (flushing it to memory) or from memory.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         cache-side request / snoop / completion signals
//   mem_req/mem_we      memory request (held until mem_ack), 1 = write
//   mem_addr/mem_wdata  memory address and write data
//   mem_ack/mem_rdata   memory completion, read data valid with ack
// Ops: 000 WB, 001 BusRd, 010 BusRdX, 011 BusUpgr; 1xx is illegal.
module mesi_snoop_bus_ctrl #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mesi_snoop_bus_ctrl_if.slave  bus,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_BITS-1:0]  mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_BITS-1:0]  mem_rdata
);
    localparam int IW = $clog2(NUM_CACHES);
    localparam logic [2:0] OP_WB   = 3'b000;
    localparam logic [2:0] OP_UPGR = 3'b011;

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_RESP, S_MEM_RD, S_MEM_WR, S_DONE
    } state_t;

    state_t                state_q, state_d;
    idx_t                  owner_q, owner_d;
    idx_t                  rr_q, rr_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0]  wdata_q, wdata_d;
    logic [LINE_BITS-1:0]  rdata_q, rdata_d;
    logic                  shared_q, shared_d;
    logic                  err_q, err_d;

    logic [NUM_CACHES-1:0] own_mask, shared_m, supply_m;
    logic                  win_found, sup_found;
    idx_t                  win_idx, sup_idx, cand;
    logic [2:0]            win_op;

    assign own_mask = NUM_CACHES'(1) << owner_q;
    assign shared_m = bus.snp_shared & ~own_mask;
    assign supply_m = bus.snp_supply & ~own_mask;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        shared_d = shared_q;
        err_d    = err_q;

        // Round-robin winner: first requester at or after rr_q, wrapping.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            cand = idx_t'((32'(rr_q) + i) % NUM_CACHES);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_op = bus.req_op[3*win_idx +: 3];

        // Lowest-index non-owner cache holding the line in M.
        sup_found = 1'b0;
        sup_idx   = '0;
        for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            if (!sup_found && supply_m[i]) begin
                sup_found = 1'b1;
                sup_idx   = idx_t'(i);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    op_d    = win_op;
                    addr_d  = bus.req_addr[ADDR_WIDTH*win_idx +: ADDR_WIDTH];
                    wdata_d = bus.req_wdata[LINE_BITS*win_idx +: LINE_BITS];
                    err_d   = 1'b0;
                    if (win_op[2] || (win_op == OP_WB && !bus.req_wvalid[win_idx])) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (win_op == OP_WB) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_SNOOP;
                    end
                end
            end
            S_SNOOP: state_d = S_RESP;
            S_RESP: begin
                shared_d = |shared_m;
                if (op_q == OP_UPGR) begin
                    state_d = S_DONE;
                end else if (sup_found) begin
                    // Supplied line goes to the owner and is flushed to memory.
                    rdata_d = bus.req_wdata[LINE_BITS*sup_idx +: LINE_BITS];
                    wdata_d = bus.req_wdata[LINE_BITS*sup_idx +: LINE_BITS];
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = S_DONE;
                end
            end
            S_MEM_WR: begin
                if (mem_ack) state_d = S_DONE;
            end
            S_DONE: begin
                rr_d    = (32'(owner_q) == NUM_CACHES - 1) ? '0 : owner_q + idx_t'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            shared_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            shared_q <= shared_d;
            err_q    <= err_d;
        end
    end

    // Outputs are decoded only from registered state, so reset clears them at once.
    always_comb begin
        bus.snoop_op = '0;
        if (state_q == S_SNOOP) begin
            for (int unsigned i = 0; i < NUM_CACHES; i++) begin
                if (idx_t'(i) != owner_q) bus.snoop_op[3*i +: 3] = op_q;
            end
        end
    end

    assign bus.grant      = (state_q != S_IDLE) ? own_mask : '0;
    assign bus.snoop_addr = (state_q == S_SNOOP) ? addr_q : '0;
    assign bus.rdata      = rdata_q;
    assign bus.data_ready = (state_q == S_DONE) ? own_mask : '0;
    assign bus.shared_out = shared_q;
    assign bus.err        = (state_q == S_DONE) && err_q;

    assign mem_req   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign mem_we    = (state_q == S_MEM_WR);
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = (state_q == S_MEM_WR) ? wdata_q : '0;
endmodule

// File: tb/tb_mesi_snoop_bus_ctrl.sv
// Testbench for mesi_snoop_bus_ctrl: directed vector table, hand-written
// round-robin and mid-transaction reset sequences, and randomized transactions
// checked against a transaction-level reference model.
module tb_mesi_snoop_bus_ctrl;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LB = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mesi_snoop_bus_ctrl_if #(.NUM_CACHES(N), .ADDR_WIDTH(AW), .LINE_BITS(LB)) bus ();

    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [LB-1:0] mem_wdata, mem_rdata;

    mesi_snoop_bus_ctrl #(.NUM_CACHES(N), .ADDR_WIDTH(AW), .LINE_BITS(LB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]    req;
        logic [3*N-1:0]  op;
        logic [AW-1:0]   addr;
        logic [N*LB-1:0] wdata;
        logic [N-1:0]    wvalid, shared, supply;
        int              lat;
        logic [LB-1:0]   mdata;
    } t_stim;

    typedef struct {
        int            owner;
        bit            err;
        int            snoops;
        bit            mrd, mwr;
        logic [LB-1:0] mwdata, rdata;
        bit            shared;
        int            lat;
    } t_exp;

    typedef struct {
        t_stim s;
        t_exp  e;
    } t_vec;

    // Memory model: acks on the mem_lat-th cycle of a request.
    int            mem_lat  = 1;
    logic [LB-1:0] mem_data = '0;
    int            mcnt     = 0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_ack) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                mcnt      = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [LB-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic t_stim mk_s(input logic [N-1:0] req, input logic [3*N-1:0] op,
                                   input logic [AW-1:0] addr, input logic [N-1:0] wv,
                                   input logic [N-1:0] sh, input logic [N-1:0] su,
                                   input int lat, input logic [7:0] tag, input logic [7:0] mb);
        t_stim s;
        s.req = req; s.op = op; s.addr = addr; s.wvalid = wv;
        s.shared = sh; s.supply = su; s.lat = lat; s.mdata = rep(mb);
        for (int i = 0; i < N; i++) s.wdata[i*LB +: LB] = rep(tag + 8'(i));
        return s;
    endfunction

    function automatic t_exp mk_e(input int owner, input int err, input int snoops,
                                  input int mrd, input int mwr, input logic [7:0] mwb,
                                  input logic [7:0] rb, input int sh, input int lat);
        t_exp e;
        e.owner = owner; e.err = (err != 0); e.snoops = snoops;
        e.mrd = (mrd != 0); e.mwr = (mwr != 0); e.mwdata = rep(mwb);
        e.rdata = rep(rb); e.shared = (sh != 0); e.lat = lat;
        return e;
    endfunction

    // Transaction-level reference model.
    int            m_rr;
    logic [LB-1:0] m_rdata;
    bit            m_shared;

    function automatic t_exp model(input t_stim s);
        t_exp       e;
        int         own = -1;
        int         sup = -1;
        logic [2:0] op;
        logic [N-1:0] osh, osu;
        for (int k = 0; k < N; k++) begin
            int c = (m_rr + k) % N;
            if (own < 0 && s.req[c]) own = c;
        end
        op = s.op[3*own +: 3];
        e.owner = own; e.err = 0; e.snoops = 0; e.mrd = 0; e.mwr = 0;
        e.mwdata = '0; e.lat = 0;
        if (op >= 3'd4 || (op == 3'd0 && !s.wvalid[own])) begin
            e.err = 1;
        end else if (op == 3'd0) begin
            e.mwr = 1; e.mwdata = s.wdata[own*LB +: LB]; e.lat = s.lat;
        end else begin
            e.snoops = 1;
            osh = s.shared & ~(N'(1) << own);
            osu = s.supply & ~(N'(1) << own);
            m_shared = (osh != '0);
            for (int k = N - 1; k >= 0; k--) if (osu[k]) sup = k;
            if (op == 3'd3) begin
                e.lat = 2;
            end else if (sup >= 0) begin
                m_rdata = s.wdata[sup*LB +: LB];
                e.mwr = 1; e.mwdata = m_rdata; e.lat = 2 + s.lat;
            end else begin
                m_rdata = s.mdata;
                e.mrd = 1; e.lat = 2 + s.lat;
            end
        end
        e.rdata = m_rdata; e.shared = m_shared;
        m_rr = (own + 1) % N;
        return e;
    endfunction

    // Applies one stimulus and watches the resulting transaction to data_ready.
    // The owner drops its req as soon as it is granted; that must not matter.
    task automatic run(input t_stim s, input t_exp e, input string nm);
        logic [N-1:0]   gobs = '0;
        logic [N-1:0]   oh   = N'(1) << e.owner;
        logic [3*N-1:0] esn  = '0;
        logic [2:0]     oop  = s.op[3*e.owner +: 3];
        int  gcyc = 0, snoops = 0, errs = 0, cyc;
        bit  srd = 0, swr = 0, done = 0;
        for (int k = 0; k < N; k++) if (k != e.owner) esn[3*k +: 3] = oop;
        bus.req = s.req; bus.req_op = s.op; bus.req_addr = {N{s.addr}};
        bus.req_wdata = s.wdata; bus.req_wvalid = s.wvalid;
        bus.snp_shared = s.shared; bus.snp_supply = s.supply;
        mem_lat = s.lat; mem_data = s.mdata;
        for (cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (gobs == '0 && bus.grant != '0) begin
                gobs = bus.grant; gcyc = cyc;
                bus.req = s.req & ~bus.grant;
            end
            if (bus.snoop_op != '0) begin
                snoops++;
                chk({nm, ".snoop_op"}, LB'(bus.snoop_op), LB'(esn));
                chk({nm, ".snoop_addr"}, LB'(bus.snoop_addr), LB'(s.addr));
            end
            if (mem_req) begin
                if (mem_we) swr = 1; else srd = 1;
                chk({nm, ".mem_addr"}, LB'(mem_addr), LB'(s.addr));
                if (mem_we) chk({nm, ".mem_wdata"}, mem_wdata, e.mwdata);
            end
            if (bus.err) errs++;
            if (bus.data_ready != '0) begin
                done = 1;
                chk({nm, ".grant"}, LB'(gobs), LB'(oh));
                chk({nm, ".data_ready"}, LB'(bus.data_ready), LB'(oh));
                chk({nm, ".latency"}, LB'(cyc - gcyc), LB'(e.lat));
                chk({nm, ".rdata"}, bus.rdata, e.rdata);
                chk({nm, ".shared_out"}, LB'(bus.shared_out), LB'(e.shared));
                chk({nm, ".snoop_cycles"}, LB'(snoops), LB'(e.snoops));
                chk({nm, ".mem_read"}, LB'(srd), LB'(e.mrd));
                chk({nm, ".mem_write"}, LB'(swr), LB'(e.mwr));
                chk({nm, ".err"}, LB'(errs), LB'(e.err));
            end
        end
        if (!done) chk({nm, ".timeout"}, LB'(done), LB'(1'b1));
        bus.req = '0;
    endtask

    task automatic do_reset();
        bus.req = '0; bus.snp_shared = '0; bus.snp_supply = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    t_vec vec[9];

    initial begin
        bus.req = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_wvalid = '0; bus.snp_shared = '0; bus.snp_supply = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.grant", LB'(bus.grant), '0);
        chk("rst.data_ready", LB'(bus.data_ready), '0);
        chk("rst.snoop_op", LB'(bus.snoop_op), '0);
        chk("rst.rdata", bus.rdata, '0);
        chk("rst.shared_err", LB'({bus.shared_out, bus.err}), '0);
        chk("rst.mem", LB'({mem_req, mem_we, mem_addr}), '0);
        rst_n = 1'b1;

        //            req      op        addr      wv       shared   supply  lat tag    mem
        vec[0] = '{mk_s(4'b0001, 12'o0001, 32'h100,  4'b0000, 4'b0000, 4'b0000, 3, 8'h00, 8'hA5),
                   mk_e(0, 0, 1, 1, 0, 8'h00, 8'hA5, 0, 5)};
        vec[1] = '{mk_s(4'b0010, 12'o0020, 32'h200,  4'b0000, 4'b1010, 4'b1010, 1, 8'h57, 8'hEE),
                   mk_e(1, 0, 1, 0, 1, 8'h5A, 8'h5A, 1, 3)};
        vec[2] = '{mk_s(4'b0100, 12'o0300, 32'h1000, 4'b0000, 4'b0001, 4'b0000, 1, 8'h00, 8'h00),
                   mk_e(2, 0, 1, 0, 0, 8'h00, 8'h5A, 1, 2)};
        vec[3] = '{mk_s(4'b0001, 12'o0000, 32'h40,   4'b0001, 4'b1110, 4'b1110, 2, 8'h10, 8'h00),
                   mk_e(0, 0, 0, 0, 1, 8'h10, 8'h5A, 1, 2)};
        vec[4] = '{mk_s(4'b0001, 12'o0005, 32'h80,   4'b0000, 4'b0000, 4'b0000, 1, 8'h00, 8'h00),
                   mk_e(0, 1, 0, 0, 0, 8'h00, 8'h5A, 1, 0)};
        vec[5] = '{mk_s(4'b0010, 12'o0000, 32'h80,   4'b0001, 4'b0000, 4'b0000, 1, 8'h00, 8'h00),
                   mk_e(1, 1, 0, 0, 0, 8'h00, 8'h5A, 1, 0)};
        vec[6] = '{mk_s(4'b1111, 12'o1111, 32'h300,  4'b0000, 4'b0000, 4'b0000, 1, 8'h00, 8'h33),
                   mk_e(2, 0, 1, 1, 0, 8'h00, 8'h33, 0, 3)};
        vec[7] = '{mk_s(4'b1011, 12'o1011, 32'h400,  4'b0000, 4'b0110, 4'b0110, 2, 8'h20, 8'h00),
                   mk_e(3, 0, 1, 0, 1, 8'h21, 8'h21, 1, 4)};
        vec[8] = '{mk_s(4'b0001, 12'o0002, 32'h500,  4'b0000, 4'b0001, 4'b0001, 1, 8'h00, 8'h77),
                   mk_e(0, 0, 1, 1, 0, 8'h00, 8'h77, 0, 3)};
        for (int i = 0; i < 9; i++) run(vec[i].s, vec[i].e, $sformatf("vec%0d", i));

        // Round robin: c0,c2 together, then both again -> c0, c2, c0.
        do_reset();
        begin
            logic [N-1:0] order [3] = '{4'b0001, 4'b0100, 4'b0001};
            bus.req_op = 12'o3333; bus.req_addr = {N{32'h600}};
            bus.req = 4'b0101;
            for (int n = 0; n < 3; n++) begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (bus.data_ready != '0) break;
                end
                chk($sformatf("rr_order%0d", n), LB'(bus.data_ready), LB'(order[n]));
                bus.req = bus.req & ~bus.data_ready;
                if (n == 1) bus.req = 4'b0101;
            end
            bus.req = '0;
        end

        // Reset during MEM_RD abandons the transaction and restores rr_ptr to 0.
        do_reset();
        run(mk_s(4'b0100, 12'o0300, 32'h80, 4'b0, 4'b0, 4'b0, 1, 8'h00, 8'h00),
            mk_e(2, 0, 1, 0, 0, 8'h00, 8'h00, 0, 2), "pre_rst");
        bus.req = 4'b1000; bus.req_op = 12'o1000; mem_lat = 50;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("midrst.mem_started", LB'({mem_req, mem_we}), LB'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.grant", LB'(bus.grant), '0);
        chk("midrst.mem_req", LB'(mem_req), '0);
        chk("midrst.data_ready", LB'(bus.data_ready), '0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(mk_s(4'b1010, 12'o3030, 32'hC0, 4'b0, 4'b0, 4'b0, 1, 8'h00, 8'h00),
            mk_e(1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 2), "post_rst");

        // Randomized transactions against the reference model.
        do_reset();
        m_rr = 0; m_rdata = '0; m_shared = 0;
        for (int t = 0; t < 200; t++) begin
            t_stim s;
            t_exp  e;
            int    r;
            s.req = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 15);
                s.op[3*i +: 3] = (r < 13) ? 3'(r % 4) : 3'(r - 9);
            end
            s.addr   = $urandom & ~32'h1F;
            s.wvalid = N'($urandom);
            s.shared = N'($urandom);
            s.supply = N'($urandom);
            s.lat    = $urandom_range(1, 4);
            for (int w = 0; w < N*LB/32; w++) s.wdata[w*32 +: 32] = $urandom;
            for (int w = 0; w < LB/32; w++) s.mdata[w*32 +: 32] = $urandom;
            e = model(s);
            run(s, e, $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
